// File: rtl/cache_core_dm.sv
// cache_core_dm: direct-mapped, write-through, no-write-allocate cache core.
// One word per line. Packets {addr,wdata,wstrb,we} arrive on pkt_*; read data
// leaves on rsp_*; single-beat requests go to backing memory on mem_req_*,
// with read data returned on mem_rsp_* (valid only, no back-pressure).
// flush_i invalidates all lines while idle; hit/miss counters saturate.
module cache_core_dm #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DATA_BYTES = DATA_WIDTH / 8,
    parameter int FIFO_WIDTH = ADDR_WIDTH + DATA_WIDTH + DATA_BYTES + 1,
    parameter int LINES      = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  aclk_i,
    input  logic                  arstn_i,
    input  logic [FIFO_WIDTH-1:0] pkt_data_i,
    input  logic                  pkt_valid_i,
    output logic                  pkt_ready_o,
    input  logic                  cpu_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_valid_o,
    input  logic                  flush_i,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic                  mem_req_we_o,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
    output logic [DATA_WIDTH-1:0] mem_req_wdata_o,
    output logic [DATA_BYTES-1:0] mem_req_wstrb_o,
    input  logic                  mem_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data_i,
    output logic [CNT_WIDTH-1:0]  hit_cnt_o,
    output logic [CNT_WIDTH-1:0]  miss_cnt_o
);
    localparam int OFF_W = $clog2(DATA_BYTES);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W;
    localparam int WA_W  = ADDR_WIDTH - OFF_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MEM_WR,
        S_MEM_RD,
        S_MEM_WAIT,
        S_RESP
    } state_t;

    state_t                 state_q;
    logic [LINES-1:0]       valid_q;
    logic [TAG_W-1:0]       tag_arr_q  [LINES];
    logic [DATA_WIDTH-1:0]  data_arr_q [LINES];
    logic [WA_W-1:0]        waddr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [DATA_BYTES-1:0]  wstrb_q;
    logic                   we_q;
    logic [DATA_WIDTH-1:0]  rsp_data_q;
    logic                   mreq_valid_q;
    logic [CNT_WIDTH-1:0]   hit_cnt_q;
    logic [CNT_WIDTH-1:0]   miss_cnt_q;

    logic [ADDR_WIDTH-1:0]  pkt_addr;
    logic                   unused_off;
    logic [IDX_W-1:0]       idx;
    logic [TAG_W-1:0]       tag;
    logic                   hit;
    logic                   wr_hit;
    logic                   fill;
    logic [DATA_WIDTH-1:0]  merged_d;

    // Byte offset never takes part in lookup or memory addressing.
    assign pkt_addr   = pkt_data_i[FIFO_WIDTH-1 -: ADDR_WIDTH];
    assign unused_off = ^pkt_addr[OFF_W-1:0];

    assign idx    = waddr_q[IDX_W-1:0];
    assign tag    = waddr_q[WA_W-1 -: TAG_W];
    assign hit    = valid_q[idx] && (tag_arr_q[idx] == tag);
    assign wr_hit = (state_q == S_LOOKUP) && we_q && hit;
    assign fill   = (state_q == S_MEM_WAIT) && mem_rsp_valid_i;

    assign pkt_ready_o     = (state_q == S_IDLE) && !flush_i;
    assign rsp_valid_o     = (state_q == S_RESP) && cpu_ready_i;
    assign rsp_data_o      = rsp_data_q;
    assign mem_req_valid_o = mreq_valid_q;
    assign mem_req_we_o    = we_q;
    assign mem_req_addr_o  = {waddr_q, {OFF_W{1'b0}}};
    assign mem_req_wdata_o = wdata_q;
    assign mem_req_wstrb_o = wstrb_q;
    assign hit_cnt_o       = hit_cnt_q;
    assign miss_cnt_o      = miss_cnt_q;

    always_comb begin
        merged_d = data_arr_q[idx];
        for (int b = 0; b < DATA_BYTES; b++) begin
            if (wstrb_q[b]) merged_d[b*8 +: 8] = wdata_q[b*8 +: 8];
        end
    end

    // Tag/data storage carries no reset; valid_q alone qualifies it.
    always_ff @(posedge aclk_i) begin
        if (wr_hit) data_arr_q[idx] <= merged_d;
        if (fill) begin
            tag_arr_q[idx]  <= tag;
            data_arr_q[idx] <= mem_rsp_data_i;
        end
    end

    always_ff @(posedge aclk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            we_q         <= 1'b0;
            rsp_data_q   <= '0;
            mreq_valid_q <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (flush_i) begin
                        valid_q <= '0;
                    end else if (pkt_valid_i) begin
                        waddr_q <= pkt_addr[ADDR_WIDTH-1:OFF_W];
                        wdata_q <= pkt_data_i[DATA_BYTES+1 +: DATA_WIDTH];
                        wstrb_q <= pkt_data_i[1 +: DATA_BYTES];
                        we_q    <= pkt_data_i[0];
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        if (!(&hit_cnt_q)) hit_cnt_q <= hit_cnt_q + 1'b1;
                    end else begin
                        if (!(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + 1'b1;
                    end
                    if (we_q) begin
                        mreq_valid_q <= 1'b1;
                        state_q      <= S_MEM_WR;
                    end else if (hit) begin
                        rsp_data_q <= data_arr_q[idx];
                        state_q    <= S_RESP;
                    end else begin
                        mreq_valid_q <= 1'b1;
                        state_q      <= S_MEM_RD;
                    end
                end
                S_MEM_WR: begin
                    if (mem_req_ready_i) begin
                        mreq_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                S_MEM_RD: begin
                    if (mem_req_ready_i) begin
                        mreq_valid_q <= 1'b0;
                        state_q      <= S_MEM_WAIT;
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_rsp_valid_i) begin
                        valid_q[idx] <= 1'b1;
                        rsp_data_q   <= mem_rsp_data_i;
                        state_q      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (cpu_ready_i) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_core_dm.sv
// tb_cache_core_dm: scoreboard bench for cache_core_dm.
// A line-level cache/memory model predicts responses and memory requests.
module tb_cache_core_dm;
    logic        aclk_i;
    logic        arstn_i;
    logic [68:0] pkt_data_i;
    logic        pkt_valid_i;
    logic        pkt_ready_o;
    logic        cpu_ready_i;
    logic [31:0] rsp_data_o;
    logic        rsp_valid_o;
    logic        flush_i;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic        mem_req_we_o;
    logic [31:0] mem_req_addr_o;
    logic [31:0] mem_req_wdata_o;
    logic [3:0]  mem_req_wstrb_o;
    logic        mem_rsp_valid_i;
    logic [31:0] mem_rsp_data_i;
    logic [15:0] hit_cnt_o;
    logic [15:0] miss_cnt_o;

    cache_core_dm dut (
        .aclk_i          (aclk_i),
        .arstn_i         (arstn_i),
        .pkt_data_i      (pkt_data_i),
        .pkt_valid_i     (pkt_valid_i),
        .pkt_ready_o     (pkt_ready_o),
        .cpu_ready_i     (cpu_ready_i),
        .rsp_data_o      (rsp_data_o),
        .rsp_valid_o     (rsp_valid_o),
        .flush_i         (flush_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_we_o    (mem_req_we_o),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_req_wdata_o (mem_req_wdata_o),
        .mem_req_wstrb_o (mem_req_wstrb_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .hit_cnt_o       (hit_cnt_o),
        .miss_cnt_o      (miss_cnt_o)
    );

    typedef struct {
        logic [31:0] data;
        int          h;
        int          m;
        int          exact;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          h;
        int          m;
        int          exact;
    } req_t;

    rsp_t rsp_q[$];
    req_t req_q[$];

    // Reference model: per-line word address, plus flat memory.
    bit          m_valid [16];
    int unsigned m_word  [16];
    logic [31:0] m_data  [16];
    logic [31:0] mem [int unsigned];
    int          exp_hit;
    int          exp_miss;

    int  n_pass;
    int  n_chk;
    int  cyc;
    bit  directed;
    bit  bp_hold;
    int  rsp_delay;
    int  rsp_cnt;
    int unsigned pend;
    int  last_mrsp_cyc;

    initial aclk_i = 1'b0;
    always #5 aclk_i = ~aclk_i;
    always @(posedge aclk_i) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic bad(input string nm);
        n_chk++;
        $display("FAIL %s", nm);
    endtask

    function automatic logic [31:0] mrg(input logic [31:0] o,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic void mem_touch(input int unsigned w);
        if (!mem.exists(w)) mem[w] = $urandom;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        exp_hit  = 0;
        exp_miss = 0;
    endfunction

    // Issue one packet and record what the cache must do with it.
    task automatic send(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit w, input bit track);
        int t;
        int t0;
        int unsigned wd;
        int ix;
        bit h;
        rsp_t r;
        req_t q;
        @(negedge aclk_i);
        pkt_data_i  = {a, d, s, w};
        pkt_valid_i = 1'b1;
        t = 0;
        while (!pkt_ready_o && t < 300) begin
            @(negedge aclk_i);
            t++;
        end
        if (!pkt_ready_o) begin
            bad("accept_timeout");
            pkt_valid_i = 1'b0;
            return;
        end
        t0 = cyc;
        wd = a >> 2;
        ix = int'(wd % 16);
        h  = m_valid[ix] && (m_word[ix] == wd);
        if (h) begin
            if (exp_hit < 65535) exp_hit++;
        end else begin
            if (exp_miss < 65535) exp_miss++;
        end
        q.addr  = {a[31:2], 2'b00};
        q.we    = w;
        q.wdata = d;
        q.wstrb = s;
        q.h     = exp_hit;
        q.m     = exp_miss;
        q.exact = directed ? t0 + 2 : -1;
        r.h     = exp_hit;
        r.m     = exp_miss;
        if (w) begin
            if (h) m_data[ix] = mrg(m_data[ix], d, s);
            mem_touch(wd);
            mem[wd] = mrg(mem[wd], d, s);
            req_q.push_back(q);
        end else if (h) begin
            r.data  = m_data[ix];
            r.exact = (directed && !bp_hold) ? t0 + 2 : -1;
            rsp_q.push_back(r);
        end else begin
            mem_touch(wd);
            req_q.push_back(q);
            if (track) begin
                r.data  = mem[wd];
                r.exact = (directed && !bp_hold) ? -2 : -1;
                rsp_q.push_back(r);
                m_valid[ix] = 1'b1;
                m_word[ix]  = wd;
                m_data[ix]  = mem[wd];
            end
        end
        @(posedge aclk_i);
        #1 pkt_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        do begin
            @(negedge aclk_i);
            t++;
        end while (!(rsp_q.size() == 0 && req_q.size() == 0 && pkt_ready_o)
                   && t < 1000);
        if (t >= 1000) bad("drain_timeout");
    endtask

    task automatic flush();
        @(negedge aclk_i);
        flush_i = 1'b1;
        #1 chk("flush_blocks_ready", pkt_ready_o, 0);
        @(negedge aclk_i);
        flush_i = 1'b0;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    // Ready inputs change just after the rising edge.
    initial forever begin
        @(posedge aclk_i);
        #1;
        cpu_ready_i     = bp_hold ? 1'b0 :
                          (directed ? 1'b1 : ($urandom_range(0, 3) != 0));
        mem_req_ready_i = directed ? 1'b1 : ($urandom_range(0, 2) != 0);
    end

    // Response monitor.
    initial forever begin
        rsp_t r;
        @(negedge aclk_i);
        if (arstn_i && rsp_valid_o) begin
            if (!cpu_ready_i) bad("rsp_valid_without_cpu_ready");
            if (rsp_q.size() == 0) begin
                $display("FAIL unexpected_rsp: got %0h want none", rsp_data_o);
                n_chk++;
            end else begin
                r = rsp_q.pop_front();
                chk("rsp_data", rsp_data_o, r.data);
                chk("rsp_hit_cnt", hit_cnt_o, r.h);
                chk("rsp_miss_cnt", miss_cnt_o, r.m);
                if (r.exact == -2)
                    chk("miss_rsp_latency", cyc, last_mrsp_cyc + 1);
                else if (r.exact >= 0)
                    chk("hit_rsp_latency", cyc, r.exact);
            end
        end
    end

    // Memory side: request monitor plus read responder.
    initial forever begin
        req_t q;
        @(negedge aclk_i);
        mem_rsp_valid_i = 1'b0;
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                mem_rsp_valid_i = 1'b1;
                mem_rsp_data_i  = mem.exists(pend) ? mem[pend] : 32'hBAD0BAD0;
                last_mrsp_cyc   = cyc;
            end
        end else if (!directed && $urandom_range(0, 7) == 0) begin
            // Stray response while not waiting must be ignored.
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = $urandom;
        end
        if (arstn_i && mem_req_valid_o && mem_req_ready_i) begin
            if (req_q.size() == 0) begin
                $display("FAIL unexpected_mem_req: got %0h want none",
                         mem_req_addr_o);
                n_chk++;
            end else begin
                q = req_q.pop_front();
                chk("mem_addr", mem_req_addr_o, q.addr);
                chk("mem_we", mem_req_we_o, q.we);
                if (q.we) begin
                    chk("mem_wdata", mem_req_wdata_o, q.wdata);
                    chk("mem_wstrb", mem_req_wstrb_o, q.wstrb);
                end
                chk("req_hit_cnt", hit_cnt_o, q.h);
                chk("req_miss_cnt", miss_cnt_o, q.m);
                if (q.exact >= 0) chk("mem_req_latency", cyc, q.exact);
            end
            if (!mem_req_we_o) begin
                pend    = mem_req_addr_o >> 2;
                rsp_cnt = directed ? rsp_delay : $urandom_range(1, 4);
            end
        end
    end

    initial begin
        int m0;
        int t;
        logic [25:0] tg;
        logic [3:0]  ix;
        logic [1:0]  of;
        n_pass = 0;
        n_chk  = 0;
        cyc    = 0;
        rsp_cnt = 0;
        pend    = 0;
        last_mrsp_cyc = 0;
        arstn_i = 1'b1;
        pkt_valid_i = 1'b0;
        pkt_data_i  = '0;
        flush_i     = 1'b0;
        cpu_ready_i = 1'b1;
        mem_req_ready_i = 1'b1;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = '0;
        directed  = 1'b1;
        bp_hold   = 1'b0;
        rsp_delay = 3;
        model_reset();
        #1 arstn_i = 1'b0;
        repeat (3) @(negedge aclk_i);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_mem_req_valid", mem_req_valid_o, 0);
        chk("rst_rsp_data", rsp_data_o, 0);
        chk("rst_hit_cnt", hit_cnt_o, 0);
        chk("rst_miss_cnt", miss_cnt_o, 0);
        arstn_i = 1'b1;
        @(negedge aclk_i);
        chk("rst_pkt_ready", pkt_ready_o, 1);

        // Read miss then hit.
        mem[32'h10] = 32'hDEADBEEF;
        send(32'h40, 0, 0, 0, 1);
        wait_done();
        send(32'h40, 0, 0, 0, 1);
        wait_done();
        chk("t1_hit_cnt", hit_cnt_o, 1);
        chk("t1_miss_cnt", miss_cnt_o, 1);

        // Partial write hit, reread from cache.
        send(32'h40, 32'h11223344, 4'b0011, 1, 1);
        wait_done();
        send(32'h40, 0, 0, 0, 1);
        wait_done();
        chk("t2_merged_line", m_data[0], 32'hDEAD3344);

        // Write miss with no allocate, zero-strobe write hit.
        send(32'h80, 32'hCAFEF00D, 4'hF, 1, 1);
        wait_done();
        send(32'h80, 0, 0, 0, 1);
        wait_done();
        send(32'h82, 32'h55555555, 4'h0, 1, 1);
        wait_done();
        send(32'h80, 0, 0, 0, 1);
        wait_done();

        // Conflict eviction on index 0.
        flush();
        m0 = exp_miss;
        send(32'h40, 0, 0, 0, 1);
        wait_done();
        send(32'h440, 0, 0, 0, 1);
        wait_done();
        send(32'h40, 0, 0, 0, 1);
        wait_done();
        chk("t4_conflict_misses", miss_cnt_o, m0 + 3);

        // Back-pressure in RESP on a hit.
        bp_hold = 1'b1;
        repeat (2) @(negedge aclk_i);
        send(32'h40, 0, 0, 0, 1);
        @(negedge aclk_i);
        repeat (5) begin
            @(negedge aclk_i);
            chk("bp_rsp_valid", rsp_valid_o, 0);
            chk("bp_pkt_ready", pkt_ready_o, 0);
        end
        bp_hold = 1'b0;
        wait_done();

        // Reset while waiting on memory; the late response is dropped.
        flush();
        rsp_delay = 8;
        send(32'h40, 0, 0, 0, 0);
        t = 0;
        while (req_q.size() != 0 && t < 100) begin
            @(negedge aclk_i);
            t++;
        end
        if (t >= 100) bad("rst_req_timeout");
        @(negedge aclk_i);
        arstn_i = 1'b0;
        repeat (2) @(negedge aclk_i);
        arstn_i = 1'b1;
        model_reset();
        @(negedge aclk_i);
        chk("midrst_pkt_ready", pkt_ready_o, 1);
        chk("midrst_hit_cnt", hit_cnt_o, 0);
        chk("midrst_miss_cnt", miss_cnt_o, 0);
        t = 0;
        while (rsp_cnt != 0 && t < 100) begin
            @(negedge aclk_i);
            t++;
        end
        repeat (2) @(negedge aclk_i);
        chk("late_rsp_ignored", pkt_ready_o, 1);
        rsp_delay = 3;
        send(32'h40, 0, 0, 0, 1);
        wait_done();
        chk("post_rst_miss", miss_cnt_o, 1);
        send(32'h40, 0, 0, 0, 1);
        wait_done();
        flush();
        send(32'h40, 0, 0, 0, 1);
        wait_done();
        send(32'h80, 0, 0, 0, 1);
        wait_done();
        chk("flush_miss_cnt", miss_cnt_o, 3);
        chk("flush_hit_cnt", hit_cnt_o, 1);

        // Randomised traffic.
        directed = 1'b0;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0: tg = 26'h0;
                1: tg = 26'h1;
                2: tg = 26'h2;
                default: tg = 26'h3FFFFFF;
            endcase
            ix = 4'($urandom_range(0, 15));
            of = 2'($urandom_range(0, 3));
            send({tg, ix, of}, $urandom, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1);
            if (n % 50 == 49) begin
                wait_done();
                flush();
            end
        end
        wait_done();
        chk("final_hit_cnt", hit_cnt_o, exp_hit);
        chk("final_miss_cnt", miss_cnt_o, exp_miss);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
